wash_sequencer: RTL and testbench

//   Runs the wash programme once the pre-stage hands over a confirmed mode and balance.

---
 rtl/wash_sequencer.sv | 179 +++++++++++++++++
 tb/tb_wash_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_sequencer.sv
// Wash programme sequencer: charges the programme price, then steps WASH -> RINSE -> SPIN
// on per-second ticks with pause/resume, reporting phase, seconds left and balance.
module wash_sequencer #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [9:0] bal_in,
    output logic       busy,
    output logic [3:0] phase,
    output logic       paused,
    output logic [5:0] remain,
    output logic [9:0] bal_out,
    output logic       done,
    output logic       err
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        WASH,
        RINSE,
        SPIN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    state_t        saved;
    state_t        next_idle;
    state_t        next_cur;
    logic [1:0]    mode_q;
    logic [TW-1:0] tick;

    function automatic logic [9:0] price(input logic [1:0] m);
        case (m)
            2'd0:    price = 10'd5;
            2'd1:    price = 10'd8;
            2'd2:    price = 10'd12;
            default: price = 10'd3;
        endcase
    endfunction

    function automatic logic [5:0] dur(input logic [1:0] m, input state_t s);
        dur = 6'd0;
        case (s)
            WASH: begin
                case (m)
                    2'd0:    dur = 6'd10;
                    2'd1:    dur = 6'd20;
                    2'd2:    dur = 6'd30;
                    default: dur = 6'd0;
                endcase
            end
            RINSE: begin
                case (m)
                    2'd0:    dur = 6'd5;
                    2'd1:    dur = 6'd10;
                    2'd2:    dur = 6'd15;
                    default: dur = 6'd0;
                endcase
            end
            SPIN: begin
                case (m)
                    2'd0:    dur = 6'd5;
                    2'd1:    dur = 6'd10;
                    2'd2:    dur = 6'd15;
                    default: dur = 6'd10;
                endcase
            end
            default: dur = 6'd0;
        endcase
    endfunction

    // First phase after 'from' with a nonzero duration; IDLE means "from the top".
    function automatic state_t next_run(input logic [1:0] m, input state_t from);
        if (from == IDLE && dur(m, WASH) != 6'd0)
            next_run = WASH;
        else if ((from == IDLE || from == WASH) && dur(m, RINSE) != 6'd0)
            next_run = RINSE;
        else if (from != SPIN && dur(m, SPIN) != 6'd0)
            next_run = SPIN;
        else
            next_run = DONE;
    endfunction

    function automatic logic [3:0] phase_of(input state_t s);
        case (s)
            WASH:    phase_of = 4'b0001;
            RINSE:   phase_of = 4'b0010;
            SPIN:    phase_of = 4'b0100;
            DONE:    phase_of = 4'b1000;
            default: phase_of = 4'b0000;
        endcase
    endfunction

    always_comb begin
        next_idle = next_run(mode, IDLE);
        next_cur  = next_run(mode_q, state);
    end

    always_ff @(posedge clk) begin
        done <= 1'b0;
        err  <= 1'b0;
        if (rst) begin
            state   <= IDLE;
            saved   <= IDLE;
            mode_q  <= '0;
            tick    <= '0;
            busy    <= 1'b0;
            phase   <= '0;
            paused  <= 1'b0;
            remain  <= '0;
            bal_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bal_out <= bal_in;
                    if (start) begin
                        if (bal_in >= price(mode)) begin
                            mode_q  <= mode;
                            bal_out <= bal_in - price(mode);
                            state   <= next_idle;
                            phase   <= phase_of(next_idle);
                            remain  <= dur(mode, next_idle);
                            tick    <= '0;
                            busy    <= (next_idle != DONE);
                            done    <= (next_idle == DONE);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WASH, RINSE, SPIN: begin
                    // Pause wins over a coincident wrap: tick and remain stay frozen.
                    if (pause) begin
                        saved  <= state;
                        state  <= PAUSE;
                        paused <= 1'b1;
                    end else if (tick == TICK_MAX) begin
                        tick <= '0;
                        if (remain == 6'd1) begin
                            state  <= next_cur;
                            phase  <= phase_of(next_cur);
                            remain <= dur(mode_q, next_cur);
                            busy   <= (next_cur != DONE);
                            done   <= (next_cur == DONE);
                        end else begin
                            remain <= remain - 6'd1;
                        end
                    end else begin
                        tick <= tick + TW'(1);
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state  <= saved;
                        paused <= 1'b0;
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= IDLE;
                        phase <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer: expected output snapshots are queued as stimulus
// is driven and popped for comparison once the DUT has had its cycles.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       pause;
    logic [1:0] mode;
    logic [9:0] bal_in;
    logic       busy;
    logic [3:0] phase;
    logic       paused;
    logic [5:0] remain;
    logic [9:0] bal_out;
    logic       done;
    logic       err;

    wash_sequencer #(.TICK_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .pause  (pause),
        .mode   (mode),
        .bal_in (bal_in),
        .busy   (busy),
        .phase  (phase),
        .paused (paused),
        .remain (remain),
        .bal_out(bal_out),
        .done   (done),
        .err    (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [3:0] phase;
        logic       paused;
        logic [5:0] remain;
        logic [9:0] bal;
        logic       done;
        logic       err;
    } snap_t;

    typedef struct {
        string tag;
        snap_t val;
        snap_t mask;
    } exp_t;

    exp_t  sb[$];
    snap_t obs;
    int    total  = 0;
    int    passed = 0;

    assign obs = '{busy: busy, phase: phase, paused: paused, remain: remain,
                   bal: bal_out, done: done, err: err};

    function automatic snap_t mk(input logic b, input logic [3:0] ph, input logic pa,
                                 input logic [5:0] r, input logic [9:0] bal,
                                 input logic d, input logic e);
        mk = '{busy: b, phase: ph, paused: pa, remain: r, bal: bal, done: d, err: e};
    endfunction

    task automatic expect_snap(input string tag, input snap_t v, input snap_t m);
        exp_t e;
        e.tag  = tag;
        e.val  = v;
        e.mask = m;
        sb.push_back(e);
    endtask

    task automatic expect_all(input string tag, input snap_t v);
        expect_snap(tag, v, '1);
    endtask

    task automatic check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert ((obs & e.mask) === (e.val & e.mask)) passed++;
            else $error("FAIL %s observed busy/phase/paused/remain/bal/done/err=%b/%b/%b/%0d/%0d/%b/%b expected=%b/%b/%b/%0d/%0d/%b/%b",
                        e.tag, obs.busy, obs.phase, obs.paused, obs.remain, obs.bal, obs.done, obs.err,
                        e.val.busy, e.val.phase, e.val.paused, e.val.remain, e.val.bal, e.val.done, e.val.err);
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle(1);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause = 1'b1;
        cycle(1);
        pause = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; mode = 2'd0; bal_in = 10'd0;
        expect_all("reset", mk(0, 4'b0000, 0, 0, 0, 0, 0));
        cycle(2);
        check();
        rst = 1'b0;

        // T1: quick programme through to DONE
        bal_in = 10'd20; mode = 2'd0;
        expect_all("idle_track_pause_ignored", mk(0, 4'b0000, 0, 0, 20, 0, 0));
        pulse_pause();
        check();
        expect_all("t1_start", mk(1, 4'b0001, 0, 10, 15, 0, 0));
        pulse_start();
        check();
        expect_all("t1_wash_before_tick", mk(1, 4'b0001, 0, 10, 15, 0, 0));
        cycle(3);
        check();
        expect_all("t1_wash_first_tick", mk(1, 4'b0001, 0, 9, 15, 0, 0));
        cycle(1);
        check();
        expect_all("t1_rinse", mk(1, 4'b0010, 0, 5, 15, 0, 0));
        cycle(36);
        check();
        expect_all("t1_spin", mk(1, 4'b0100, 0, 5, 15, 0, 0));
        cycle(20);
        check();
        expect_all("t1_done_pulse", mk(0, 4'b1000, 0, 0, 15, 1, 0));
        cycle(20);
        check();
        expect_all("t1_done_hold", mk(0, 4'b1000, 0, 0, 15, 0, 0));
        cycle(1);
        check();

        // T5b: start in DONE returns to IDLE, then balance tracks bal_in
        bal_in = 10'd33;
        expect_snap("done_start_idle", mk(0, 4'b0000, 0, 0, 0, 0, 0),
                    mk(1, 4'b1111, 1, 6'h3F, 10'h000, 1, 1));
        pulse_start();
        check();
        expect_all("idle_tracks", mk(0, 4'b0000, 0, 0, 33, 0, 0));
        cycle(1);
        check();

        // T2: balance too low
        mode = 2'd2; bal_in = 10'd11;
        expect_all("t2_err", mk(0, 4'b0000, 0, 0, 11, 0, 1));
        pulse_start();
        check();
        expect_all("t2_err_clears", mk(0, 4'b0000, 0, 0, 11, 0, 0));
        cycle(1);
        check();

        // T3: spin-only with exact balance
        mode = 2'd3; bal_in = 10'd3;
        expect_all("t3_spin_start", mk(1, 4'b0100, 0, 10, 0, 0, 0));
        pulse_start();
        check();
        expect_all("t3_last_second", mk(1, 4'b0100, 0, 1, 0, 0, 0));
        cycle(39);
        check();
        expect_all("t3_done", mk(0, 4'b1000, 0, 0, 0, 1, 0));
        cycle(1);
        check();
        pulse_start();
        cycle(1);

        // T4: pause/resume preserves remain and tick
        mode = 2'd1; bal_in = 10'd50;
        expect_all("t4_start", mk(1, 4'b0001, 0, 20, 42, 0, 0));
        pulse_start();
        check();
        cycle(14);
        expect_all("t4_paused", mk(1, 4'b0001, 1, 17, 42, 0, 0));
        pulse_pause();
        check();
        expect_all("t4_pause_hold_start_ignored", mk(1, 4'b0001, 1, 17, 42, 0, 0));
        cycle(50);
        pulse_start();
        cycle(49);
        check();
        expect_all("t4_resume", mk(1, 4'b0001, 0, 17, 42, 0, 0));
        pulse_pause();
        check();
        expect_all("t4_resume_plus1", mk(1, 4'b0001, 0, 17, 42, 0, 0));
        cycle(1);
        check();
        expect_all("t4_resume_plus2", mk(1, 4'b0001, 0, 16, 42, 0, 0));
        cycle(1);
        check();

        // Pause on the wrap cycle: no decrement
        cycle(3);
        expect_all("pause_beats_wrap", mk(1, 4'b0001, 1, 16, 42, 0, 0));
        pulse_pause();
        check();
        expect_all("resume_at_wrap", mk(1, 4'b0001, 0, 15, 42, 0, 0));
        pulse_pause();
        cycle(1);
        check();

        // T5a: start while running is ignored
        bal_in = 10'd99;
        expect_all("t5_start_in_wash", mk(1, 4'b0001, 0, 15, 42, 0, 0));
        pulse_start();
        check();
        expect_all("t4_rinse", mk(1, 4'b0010, 0, 10, 42, 0, 0));
        cycle(59);
        check();

        // T6: reset mid-RINSE, then a normal restart
        cycle(5);
        rst = 1'b1;
        expect_all("t6_reset", mk(0, 4'b0000, 0, 0, 0, 0, 0));
        cycle(1);
        check();
        rst = 1'b0; mode = 2'd0; bal_in = 10'd20;
        expect_all("t6_idle", mk(0, 4'b0000, 0, 0, 20, 0, 0));
        cycle(1);
        check();
        expect_all("t6_start_with_pause", mk(1, 4'b0001, 0, 10, 15, 0, 0));
        start = 1'b1; pause = 1'b1;
        cycle(1);
        start = 1'b0; pause = 1'b0;
        check();

        total++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
